// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: opcode constants, the register-write predicate
// and the forwarding history entry type.
package pipeline_pkg;

   localparam logic [3:0] OP_BRANCH = 4'b0010;
   localparam logic [3:0] OP_SW     = 4'b0011;
   localparam logic [3:0] OP_ADD    = 4'b1100;

   // Entry fields are sized for the widest configuration; users zero-extend
   // narrower indices and data into them.
   localparam int MAX_INDEX_W = 16;
   localparam int MAX_DATA_W  = 128;

   typedef struct packed {
      logic                   valid;
      logic [MAX_INDEX_W-1:0] index;
      logic [MAX_DATA_W-1:0]  data;
   } fwd_entry_t;

   function automatic logic is_reg_write(input logic [3:0] opcode);
      return (opcode != OP_BRANCH) && (opcode != OP_SW);
   endfunction

endpackage

// File: rtl/fwd_match_port.sv
// One operand-read port: youngest-first priority mux over the live writeback
// bypass, the history slots and finally the register-file read data.
module fwd_match_port
   import pipeline_pkg::*;
#(
   parameter int REG_INDEX_BIT_WIDTH = 4,
   parameter int BITWIDTH            = 32,
   parameter int DEPTH               = 3
) (
   input  logic                           force_miss,
   input  fwd_entry_t                     bypass,
   input  fwd_entry_t [DEPTH-1:0]         history,
   input  logic [REG_INDEX_BIT_WIDTH-1:0] rd_index,
   input  logic [BITWIDTH-1:0]            rd_data,
   output logic [BITWIDTH-1:0]            fwd_data,
   output logic                           fwd_hit
);

   logic [MAX_INDEX_W-1:0] key;
   logic                   unused_entry_bits;

   // Sources are scanned oldest to youngest so the youngest match overwrites.
   always_comb begin
      key                          = '0;
      key[REG_INDEX_BIT_WIDTH-1:0] = rd_index;
      fwd_data                     = rd_data;
      fwd_hit                      = 1'b0;
      for (int k = DEPTH - 1; k >= 0; k--) begin
         if (history[k].valid && (history[k].index == key)) begin
            fwd_hit  = 1'b1;
            fwd_data = history[k].data[BITWIDTH-1:0];
         end
      end
      if (bypass.valid && (bypass.index == key)) begin
         fwd_hit  = 1'b1;
         fwd_data = bypass.data[BITWIDTH-1:0];
      end
      if (force_miss) begin
         fwd_hit  = 1'b0;
         fwd_data = rd_data;
      end
   end

   assign unused_entry_bits = ^{bypass, history};

endmodule

// File: rtl/forwarding_history_unit.sv
// Writeback forwarding unit: DEPTH-entry history of retired register writes,
// per-port youngest-first forwarding, and a saturating forward-hit counter.
module forwarding_history_unit
   import pipeline_pkg::*;
#(
   parameter int REG_INDEX_BIT_WIDTH = 4,
   parameter int BITWIDTH            = 32,
   parameter int DEPTH               = 3,
   parameter int NUM_READ_PORTS      = 2,
   parameter int CNT_WIDTH           = 16
) (
   input  logic                                          clk,
   input  logic                                          rst,
   input  logic                                          stall,
   input  logic                                          flush,
   input  logic                                          wb_valid,
   input  logic [3:0]                                    wb_opcode,
   input  logic [REG_INDEX_BIT_WIDTH-1:0]                wb_index,
   input  logic [BITWIDTH-1:0]                           wb_data,
   input  logic [NUM_READ_PORTS*REG_INDEX_BIT_WIDTH-1:0] rd_index,
   input  logic [NUM_READ_PORTS*BITWIDTH-1:0]            rd_data,
   output logic [NUM_READ_PORTS*BITWIDTH-1:0]            fwd_data,
   output logic [NUM_READ_PORTS-1:0]                     fwd_hit,
   output logic [CNT_WIDTH-1:0]                          fwd_count
);

   localparam int SUM_W = CNT_WIDTH + $clog2(NUM_READ_PORTS + 1);

   fwd_entry_t [DEPTH-1:0] history_q, history_d;
   fwd_entry_t             live_entry;
   logic [CNT_WIDTH-1:0]   fwd_count_q, fwd_count_d;
   logic [SUM_W-1:0]       hit_sum;

   // A non-writing instruction yields an invalid entry, which doubles as the bubble.
   always_comb begin
      live_entry                                = '0;
      live_entry.valid                          = wb_valid && is_reg_write(wb_opcode);
      live_entry.index[REG_INDEX_BIT_WIDTH-1:0] = wb_index;
      live_entry.data[BITWIDTH-1:0]             = wb_data;
   end

   always_comb begin
      history_d = history_q;
      if (flush) begin
         for (int k = 0; k < DEPTH; k++) history_d[k].valid = 1'b0;
      end else if (!stall) begin
         for (int k = DEPTH - 1; k > 0; k--) history_d[k] = history_q[k-1];
         history_d[0] = live_entry;
      end
   end

   always_comb begin
      hit_sum = SUM_W'(fwd_count_q);
      for (int p = 0; p < NUM_READ_PORTS; p++) hit_sum = hit_sum + SUM_W'(fwd_hit[p]);
      if (hit_sum > SUM_W'({CNT_WIDTH{1'b1}})) fwd_count_d = '1;
      else                                     fwd_count_d = hit_sum[CNT_WIDTH-1:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         history_q   <= '0;
         fwd_count_q <= '0;
      end else begin
         history_q   <= history_d;
         fwd_count_q <= fwd_count_d;
      end
   end

   assign fwd_count = fwd_count_q;

   for (genvar p = 0; p < NUM_READ_PORTS; p++) begin : g_port
      fwd_match_port #(
         .REG_INDEX_BIT_WIDTH(REG_INDEX_BIT_WIDTH),
         .BITWIDTH           (BITWIDTH),
         .DEPTH              (DEPTH)
      ) u_port (
         .force_miss(rst),
         .bypass    (live_entry),
         .history   (history_q),
         .rd_index  (rd_index[p*REG_INDEX_BIT_WIDTH +: REG_INDEX_BIT_WIDTH]),
         .rd_data   (rd_data[p*BITWIDTH +: BITWIDTH]),
         .fwd_data  (fwd_data[p*BITWIDTH +: BITWIDTH]),
         .fwd_hit   (fwd_hit[p])
      );
   end

endmodule

// File: tb/tb_forwarding_history_unit.sv
// Bench for forwarding_history_unit: directed scenarios plus random traffic,
// compared every cycle against a queue-based model of the forwarding rules.
module tb_forwarding_history_unit;

   localparam int IW    = 4;
   localparam int DW    = 32;
   localparam int DEPTH = 3;
   localparam int NP    = 2;
   localparam int CW    = 16;
   localparam int CW_S  = 2;

   logic             clk = 1'b0;
   logic             rst;
   logic             stall;
   logic             flush;
   logic             wb_valid;
   logic [3:0]       wb_opcode;
   logic [IW-1:0]    wb_index;
   logic [DW-1:0]    wb_data;
   logic [NP*IW-1:0] rd_index;
   logic [NP*DW-1:0] rd_data;
   logic [NP*DW-1:0] fwd_data, fwd_data_s;
   logic [NP-1:0]    fwd_hit, fwd_hit_s;
   logic [CW-1:0]    fwd_count;
   logic [CW_S-1:0]  fwd_count_s;

   forwarding_history_unit #(
      .REG_INDEX_BIT_WIDTH(IW), .BITWIDTH(DW), .DEPTH(DEPTH),
      .NUM_READ_PORTS(NP), .CNT_WIDTH(CW)
   ) dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush),
      .wb_valid(wb_valid), .wb_opcode(wb_opcode), .wb_index(wb_index), .wb_data(wb_data),
      .rd_index(rd_index), .rd_data(rd_data),
      .fwd_data(fwd_data), .fwd_hit(fwd_hit), .fwd_count(fwd_count)
   );

   // Same stimulus, narrow counter, to exercise saturation.
   forwarding_history_unit #(
      .REG_INDEX_BIT_WIDTH(IW), .BITWIDTH(DW), .DEPTH(DEPTH),
      .NUM_READ_PORTS(NP), .CNT_WIDTH(CW_S)
   ) dut_s (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush),
      .wb_valid(wb_valid), .wb_opcode(wb_opcode), .wb_index(wb_index), .wb_data(wb_data),
      .rd_index(rd_index), .rd_data(rd_data),
      .fwd_data(fwd_data_s), .fwd_hit(fwd_hit_s), .fwd_count(fwd_count_s)
   );

   // Clock
   always #5 clk = ~clk;

   // Reference model: history as a queue, front is youngest.
   typedef struct {
      bit            v;
      logic [IW-1:0] idx;
      logic [DW-1:0] data;
   } ent_t;

   ent_t        hist_q[$];
   int unsigned cnt_m;
   int unsigned cnt_s_m;
   int          errors = 0;
   int          checks = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic bit is_write(input logic v, input logic [3:0] op);
      return v && !(op inside {pipeline_pkg::OP_BRANCH, pipeline_pkg::OP_SW});
   endfunction

   function automatic void model_clear();
      ent_t b;
      b.v = 1'b0; b.idx = '0; b.data = '0;
      hist_q.delete();
      for (int k = 0; k < DEPTH; k++) hist_q.push_back(b);
   endfunction

   function automatic void model_lookup(input int p, output logic hit, output logic [DW-1:0] d);
      logic [IW-1:0] idx;
      idx = rd_index[p*IW +: IW];
      hit = 1'b0;
      d   = rd_data[p*DW +: DW];
      if (rst) return;
      if (is_write(wb_valid, wb_opcode) && wb_index == idx) begin
         hit = 1'b1; d = wb_data; return;
      end
      foreach (hist_q[k]) begin
         if (hist_q[k].v && hist_q[k].idx == idx) begin
            hit = 1'b1; d = hist_q[k].data; return;
         end
      end
   endfunction

   // One cycle: check outputs mid-cycle, then advance the model at the edge.
   task automatic step();
      logic [NP-1:0]    eh;
      logic [NP*DW-1:0] ed;
      logic             h;
      logic [DW-1:0]    d;
      ent_t             e;
      int unsigned      max_s;
      @(negedge clk);
      if (rst) begin
         cnt_m = 0; cnt_s_m = 0; model_clear();
      end
      for (int p = 0; p < NP; p++) begin
         model_lookup(p, h, d);
         eh[p] = h;
         ed[p*DW +: DW] = d;
      end
      check("fwd_hit", 64'(fwd_hit), 64'(eh));
      check("fwd_data", 64'(fwd_data), 64'(ed));
      check("fwd_count", 64'(fwd_count), 64'(cnt_m));
      check("fwd_hit_narrow", 64'(fwd_hit_s), 64'(eh));
      check("fwd_count_narrow", 64'(fwd_count_s), 64'(cnt_s_m));
      @(posedge clk);
      if (!rst) begin
         max_s   = (1 << CW_S) - 1;
         cnt_m   = cnt_m + $countones(eh);
         if (cnt_m > 65535) cnt_m = 65535;
         cnt_s_m = cnt_s_m + $countones(eh);
         if (cnt_s_m > max_s) cnt_s_m = max_s;
         if (flush) model_clear();
         else if (!stall) begin
            e.v = is_write(wb_valid, wb_opcode); e.idx = wb_index; e.data = wb_data;
            hist_q.push_front(e);
            void'(hist_q.pop_back());
         end
      end
      #1;
   endtask

   // Drivers
   task automatic drive_wb(input logic v, input logic [3:0] op, input logic [IW-1:0] idx,
                           input logic [DW-1:0] data);
      wb_valid = v; wb_opcode = op; wb_index = idx; wb_data = data;
   endtask

   task automatic drive_rd(input logic [IW-1:0] i0, input logic [IW-1:0] i1);
      rd_index = {i1, i0};
      rd_data  = {$urandom, $urandom};
   endtask

   task automatic drive_ctl(input logic r, input logic s, input logic f);
      rst = r; stall = s; flush = f;
   endtask

   initial begin
      model_clear();
      cnt_m = 0; cnt_s_m = 0;
      drive_ctl(1, 0, 0);
      drive_wb(1, pipeline_pkg::OP_ADD, 4'd3, 32'h33);
      drive_rd(4'd3, 4'd3);
      // Reset: bypass must be suppressed, counts zero
      step();
      step();
      drive_ctl(0, 0, 0);

      // ADD r2=2, port0 reads r2, port1 reads r0 with zero rd_data
      drive_wb(1, pipeline_pkg::OP_ADD, 4'd2, 32'h2);
      rd_index = {4'd0, 4'd2}; rd_data = '0;
      step();
      drive_wb(0, pipeline_pkg::OP_ADD, 4'd9, 32'h0);
      step();

      // Opcode filtering on r0
      drive_ctl(0, 0, 1); drive_wb(0, 4'd0, 4'd0, 32'h0); step();
      drive_ctl(0, 0, 0);
      drive_wb(1, pipeline_pkg::OP_SW, 4'd0, 32'h1);     drive_rd(4'd0, 4'd1); step();
      drive_wb(1, pipeline_pkg::OP_BRANCH, 4'd0, 32'h1); drive_rd(4'd0, 4'd1); step();
      drive_wb(1, pipeline_pkg::OP_ADD, 4'd0, 32'h1);    drive_rd(4'd0, 4'd1); step();

      // Age-out: r5 written then DEPTH+1 bubbles
      drive_ctl(0, 0, 1); drive_wb(0, 4'd0, 4'd0, 32'h0); step();
      drive_ctl(0, 0, 0);
      drive_wb(1, pipeline_pkg::OP_ADD, 4'd5, 32'hA); drive_rd(4'd5, 4'd5); step();
      drive_wb(0, pipeline_pkg::OP_ADD, 4'd5, 32'h0);
      for (int i = 0; i < DEPTH + 1; i++) begin drive_rd(4'd5, 4'd5); step(); end

      // Youngest duplicate wins
      drive_wb(1, pipeline_pkg::OP_ADD, 4'd5, 32'hA); drive_rd(4'd5, 4'd6); step();
      drive_wb(1, pipeline_pkg::OP_ADD, 4'd5, 32'hB); drive_rd(4'd5, 4'd6); step();
      drive_wb(0, pipeline_pkg::OP_ADD, 4'd0, 32'h0); drive_rd(4'd5, 4'd6); step();

      // Stall holds r7, flush clears it but still bypasses the live write
      drive_wb(1, pipeline_pkg::OP_ADD, 4'd7, 32'h7); drive_rd(4'd7, 4'd3); step();
      drive_ctl(0, 1, 0); drive_wb(1, pipeline_pkg::OP_ADD, 4'd1, 32'h55);
      for (int i = 0; i < 5; i++) begin drive_rd(4'd7, 4'd1); step(); end
      drive_ctl(0, 1, 1); drive_wb(1, pipeline_pkg::OP_ADD, 4'd3, 32'h3C); drive_rd(4'd7, 4'd3); step();
      drive_ctl(0, 0, 0); drive_wb(0, pipeline_pkg::OP_ADD, 4'd0, 32'h0); drive_rd(4'd7, 4'd3); step();

      // Counter saturation on the narrow instance, then reset mid-run
      drive_ctl(1, 0, 0); step();
      drive_ctl(0, 0, 0);
      drive_wb(1, pipeline_pkg::OP_ADD, 4'd1, 32'h11);
      for (int i = 0; i < 4; i++) begin drive_rd(4'd1, 4'd1); step(); end
      drive_ctl(1, 0, 0); step();
      drive_ctl(0, 0, 0); step();

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         drive_ctl(($urandom_range(0, 63) == 0), ($urandom_range(0, 5) == 0),
                   ($urandom_range(0, 15) == 0));
         drive_wb(($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
                  IW'($urandom_range(0, 7)), $urandom);
         drive_rd(IW'($urandom_range(0, 7)), IW'($urandom_range(0, 7)));
         step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/forwarding_history_unit.md
# forwarding_history_unit

Parametrised writeback forwarding unit. It keeps a shift-register history of the last DEPTH register writes that retired through writeback, and forwards the youngest matching value to NUM_READ_PORTS operand-read ports. Any read whose register has not yet landed in the register file gets the correct value. It sits between the register-file read stage and the execute stage, and replaces the single-entry, single-port combinational WB forwarder.

## Interface
- REG_INDEX_BIT_WIDTH, 4, register index width
- BITWIDTH, 32, data width
- DEPTH, 3, history entries retained after the WB cycle (≥1)
- NUM_READ_PORTS, 2, independent operand-read ports (≥1)
- CNT_WIDTH, 16, width of the forward-event counter
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- stall  in  1  hold history (no shift, no capture)
- flush  in  1  clear all history entries
- wb_valid  in  1  writeback stage holds a real instruction
- wb_opcode  in  4  writeback instruction opcode
- wb_index  in  REG_INDEX_BIT_WIDTH  writeback destination register
- wb_data  in  BITWIDTH  writeback result
- rd_index  in  NUM_READ_PORTS*REG_INDEX_BIT_WIDTH  packed read indices, port p at [p*W +: W]
- rd_data  in  NUM_READ_PORTS*BITWIDTH  packed register-file read data
- fwd_data  out  NUM_READ_PORTS*BITWIDTH  packed operand data after forwarding
- fwd_hit  out  NUM_READ_PORTS  port p was served from the bypass path or the history
- fwd_count  out  CNT_WIDTH  saturating count of forward hits

## Operation
- Writing instruction: wb_valid=1 and wb_opcode not in {BRANCH 4'b0010, SW 4'b0011}. Every other opcode, including ADD 4'b1100, writes its destination.
- History entry fields: {valid, index, data}. Slot 0 is the youngest.
- Capture: on a clock edge with rst=0, flush=0, stall=0 and a writing instruction present, slot 0 takes {1, wb_index, wb_data} and slot k takes slot k-1. The entry in slot DEPTH-1 is dropped.
- Non-writing cycle (stall=0, flush=0, no write): the history shifts in a bubble, {0, x, x}. Entries therefore age out after DEPTH cycles.
- stall=1: the history holds unchanged. Stall takes precedence over capture.
- flush=1: all valid bits clear on the next edge. Flush takes precedence over stall and capture.
- Lookup per port, combinational, priority youngest first:
  1. The live writeback input, if it is a writing instruction and wb_index equals the port index.
  2. Slots 0 through DEPTH-1, first valid slot whose index matches.
  3. Otherwise rd_data for that port.
- A port that matches any source gets fwd_hit=1 and that source's data.
- Duplicate indices in the history are legal. The youngest always wins.
- Register 0 is not special and forwards like any other register.
- fwd_count: on each edge with rst=0, add the popcount of fwd_hit. The counter saturates at all-ones and is not affected by stall or flush.

## Timing
- Lookup latency is 0 cycles (fwd_data and fwd_hit are combinational from the inputs and the history). History update latency is 1 cycle.
- Reset, asserted at any time and effective immediately:
  - all valid bits are 0 and fwd_count is 0;
  - fwd_hit is forced to 0 and fwd_data equals rd_data, including the bypass path.
- A write presented in cycle N:
  - is visible through the bypass in cycle N;
  - is visible from slot 0 in cycle N+1 (with no stall);
  - is gone after cycle N+DEPTH if every following cycle is a non-stalled bubble.
- A flush in cycle N still bypasses the live write in cycle N. From cycle N+1 the history is empty.
- Reset deassertion is synchronous to clk (handled externally). The first capture can happen on the first edge after deassertion.

## Structure
- Shared package, pipeline_pkg:
  - opcode constants OP_BRANCH, OP_SW, OP_ADD;
  - the is_reg_write(opcode) function;
  - the fwd_entry_t struct {valid, index, data}.
- Sub-module fwd_match_port: one instance per read port, generated. It contains the priority mux over the bypass and the DEPTH slots.
- Top level: history shift register, fwd_count, and the per-port generate loop.

## Test plan
- Defaults (DEPTH=3, NUM_READ_PORTS=2): reset → fwd_hit=2'b00, fwd_data=rd_data, fwd_count=0.
- ADD writing r2=32'h2 with port0 index 2 and port1 index 0 (rd_data 0):
  - same cycle → port0 fwd_data=32'h2, fwd_hit=2'b01;
  - following cycle with no write → port0 served from slot 0, value 32'h2.
- Opcode filtering, all driving wb_index=0 and wb_data=32'h1 with port0 index 0:
  - SW → fwd_hit[0]=0 and fwd_data equals rd_data;
  - BRANCH → fwd_hit[0]=0 and fwd_data equals rd_data;
  - ADD → fwd_data=32'h1.
- Age-out and priority:
  - write r5=32'hA, then 3 bubble cycles → hit for r5 in cycles 0–3, miss in cycle 4;
  - write r5=32'hA then r5=32'hB → port reads 32'hB.
- Stall and flush:
  - write r7=32'h7, then stall for 5 cycles → r7 still hits;
  - flush → r7 misses on the next cycle, while a write presented during the flush cycle still bypasses.
- Counter: preload near saturation using CNT_WIDTH=2 with both ports hitting every cycle → fwd_count goes 0, 2, 3, 3. Asserting rst mid-run → count returns to 0 immediately.
